// File: rtl/ysyx_22041412_mem_pkg.sv
// Shared types and constants for the IF/LSU memory arbiter.
// Holds the state encoding, the owner tag and the RISC-V load/store func3 codes.
package ysyx_22041412_mem_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_RESP = 2'd2;
   localparam state_t ST_ERR  = 2'd3;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

endpackage

// File: rtl/ysyx_22041412_mem_arbiter_if.sv
// Bus bundle between the IF/LSU requesters, the arbiter and the single-port SRAM.
// slave = arbiter view, master = requester/SRAM view.
interface ysyx_22041412_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                  if_req_valid;
   logic [ADDR_WIDTH-1:0] if_req_addr;
   logic                  if_req_ready;
   logic                  if_resp_valid;
   logic [DATA_WIDTH-1:0] if_resp_data;

   logic                  lsu_req_valid;
   logic                  lsu_req_wen;
   logic [2:0]            lsu_req_func3;
   logic [ADDR_WIDTH-1:0] lsu_req_addr;
   logic [DATA_WIDTH-1:0] lsu_req_wdata;
   logic                  lsu_req_ready;
   logic                  lsu_resp_valid;
   logic [DATA_WIDTH-1:0] lsu_resp_data;

   logic                  resp_err;

   logic                  mem_en;
   logic                  mem_wen;
   logic [2:0]            mem_func3;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_stall;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_resp_valid, if_resp_data,
      input  lsu_req_valid, lsu_req_wen, lsu_req_func3, lsu_req_addr, lsu_req_wdata,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      output resp_err,
      output mem_en, mem_wen, mem_func3, mem_addr, mem_wdata,
      input  mem_stall, mem_rdata
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_resp_valid, if_resp_data,
      output lsu_req_valid, lsu_req_wen, lsu_req_func3, lsu_req_addr, lsu_req_wdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      input  resp_err,
      input  mem_en, mem_wen, mem_func3, mem_addr, mem_wdata,
      output mem_stall, mem_rdata
   );
endinterface

// File: rtl/ysyx_22041412_mem_timeout.sv
// BUSY-cycle counter: cleared outside an access, counts while enabled,
// and flags the TIMEOUT-th counted cycle so the FSM can abandon a hung SRAM.
module ysyx_22041412_mem_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;

   // Holds at the terminal value so the flag stays stable if the FSM lingers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/ysyx_22041412_mem_arbiter.sv
// Shares the single-port SRAM between instruction fetch and the LSU.
// LSU has priority, bounded by a streak limit; one access in flight at a time.
module ysyx_22041412_mem_arbiter
   import ysyx_22041412_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int LSU_STREAK = 4,
   parameter int TIMEOUT    = 16
) (
   input logic clk,
   input logic rst,
   ysyx_22041412_mem_arbiter_if.slave io_bus
);
   localparam int SW = $clog2(LSU_STREAK + 1);

   state_t                r_state;
   state_t                w_state_next;
   owner_t                r_owner;
   logic                  r_wen;
   logic                  r_first;
   logic [2:0]            r_func3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [SW-1:0]         r_streak;

   logic                  w_idle;
   logic                  w_busy;
   logic                  w_resp;
   logic                  w_err;
   logic                  w_lsu_win;
   logic                  w_if_win;
   logic                  w_done;
   logic                  w_expired;
   logic [ADDR_WIDTH-1:0] w_grant_addr;

   // Reset gates the grant so no ready escapes while rst is held.
   assign w_idle = (r_state == ST_IDLE) && !rst;
   assign w_busy = (r_state == ST_BUSY);
   assign w_resp = (r_state == ST_RESP);
   assign w_err  = (r_state == ST_ERR);

   assign w_lsu_win = w_idle && io_bus.lsu_req_valid
                    && !(io_bus.if_req_valid && (r_streak == SW'(LSU_STREAK)));
   assign w_if_win  = w_idle && io_bus.if_req_valid && !w_lsu_win;
   assign w_grant_addr = w_lsu_win ? io_bus.lsu_req_addr : io_bus.if_req_addr;

   // The SRAM only reports ready one cycle after enable, so the first BUSY cycle is ignored.
   assign w_done = w_busy && !r_first && !io_bus.mem_stall;

   ysyx_22041412_mem_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (!w_busy),
      .i_en      (w_busy),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_lsu_win || w_if_win) begin
               w_state_next = (w_grant_addr == '0) ? ST_ERR : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_done) begin
               w_state_next = ST_RESP;
            end else if (w_expired) begin
               w_state_next = ST_ERR;
            end
         end
         ST_RESP: w_state_next = ST_IDLE;
         ST_ERR:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_owner  <= OWN_IF;
         r_wen    <= 1'b0;
         r_first  <= 1'b0;
         r_func3  <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_streak <= '0;
      end else begin
         r_state <= w_state_next;
         r_first <= w_lsu_win || w_if_win;

         if (w_lsu_win) begin
            r_owner <= OWN_LSU;
            r_wen   <= io_bus.lsu_req_wen;
            r_func3 <= io_bus.lsu_req_func3;
            r_addr  <= io_bus.lsu_req_addr;
            r_wdata <= io_bus.lsu_req_wdata;
         end else if (w_if_win) begin
            r_owner <= OWN_IF;
            r_wen   <= 1'b0;
            r_func3 <= F3_LWU;
            r_addr  <= io_bus.if_req_addr;
            r_wdata <= '0;
         end

         // Streak only grows while IF is actually waiting behind the LSU.
         if (w_if_win) begin
            r_streak <= '0;
         end else if (w_lsu_win) begin
            if (!io_bus.if_req_valid) begin
               r_streak <= '0;
            end else if (r_streak != SW'(LSU_STREAK)) begin
               r_streak <= r_streak + 1'b1;
            end
         end

         if (w_done) begin
            r_rdata <= r_wen ? '0 : io_bus.mem_rdata;
         end
      end
   end

   assign io_bus.if_req_ready   = w_if_win;
   assign io_bus.lsu_req_ready  = w_lsu_win;
   assign io_bus.if_resp_valid  = (w_resp || w_err) && (r_owner == OWN_IF);
   assign io_bus.lsu_resp_valid = (w_resp || w_err) && (r_owner == OWN_LSU);
   assign io_bus.if_resp_data   = (w_resp && (r_owner == OWN_IF))  ? r_rdata : '0;
   assign io_bus.lsu_resp_data  = (w_resp && (r_owner == OWN_LSU)) ? r_rdata : '0;
   assign io_bus.resp_err       = w_err;

   assign io_bus.mem_en    = w_busy;
   assign io_bus.mem_wen   = w_busy && r_wen;
   assign io_bus.mem_func3 = w_busy ? r_func3 : '0;
   assign io_bus.mem_addr  = w_busy ? r_addr  : '0;
   assign io_bus.mem_wdata = w_busy ? r_wdata : '0;
endmodule
